// File: rtl/gamma_window_sequencer.sv
// Opens a fixed-length capture window and converts negedge-encoded spike lines
// into per-line times (start value minus high samples), handed off with a valid/ready handshake.
module gamma_window_sequencer #(
  parameter int NUM_LINES = 4,
  parameter int MAX_VALUE = 8,
  localparam int W = $clog2(MAX_VALUE + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   clear,
  input  logic [NUM_LINES-1:0]   lines,
  input  logic                   out_ready,
  output logic                   busy,
  output logic [W-1:0]           window_count,
  output logic                   out_valid,
  output logic [NUM_LINES*W-1:0] out_times,
  output logic [NUM_LINES-1:0]   out_settled
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [W-1:0]           MAX_W   = W'(MAX_VALUE);
  localparam logic [W-1:0]           ONE_W   = W'(1);
  localparam logic [NUM_LINES*W-1:0] ALL_MAX = {NUM_LINES{MAX_W}};

  state_t                 state_reg;
  logic                   busy_reg;
  logic                   out_valid_reg;
  logic [W-1:0]           window_count_reg;
  logic [NUM_LINES*W-1:0] times_reg;
  logic [NUM_LINES*W-1:0] times_next;
  logic [NUM_LINES-1:0]   settled_reg;
  logic [NUM_LINES-1:0]   settled_next;

  // Per-line update for one RUN sample; the zero guard keeps fields from wrapping.
  generate
    for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_line
      logic [W-1:0] field;
      assign field = times_reg[gi*W +: W];
      assign times_next[gi*W +: W] = (lines[gi] && (field != '0)) ? field - ONE_W : field;
      assign settled_next[gi] = settled_reg[gi] | ~lines[gi];
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg        <= IDLE;
      busy_reg         <= 1'b0;
      out_valid_reg    <= 1'b0;
      window_count_reg <= '0;
      times_reg        <= ALL_MAX;
      settled_reg      <= '0;
    end else if (clear) begin
      // Abort keeps the last times/settled visible but drops any pending result.
      state_reg        <= IDLE;
      busy_reg         <= 1'b0;
      out_valid_reg    <= 1'b0;
      window_count_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg        <= RUN;
            busy_reg         <= 1'b1;
            window_count_reg <= MAX_W;
            times_reg        <= ALL_MAX;
            settled_reg      <= '0;
          end
        end
        RUN: begin
          times_reg        <= times_next;
          settled_reg      <= settled_next;
          window_count_reg <= window_count_reg - ONE_W;
          if (window_count_reg == ONE_W) begin
            state_reg     <= DONE;
            out_valid_reg <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            if (start) begin
              // Back-to-back window: reload without passing through IDLE.
              state_reg        <= RUN;
              window_count_reg <= MAX_W;
              times_reg        <= ALL_MAX;
              settled_reg      <= '0;
            end else begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end
          end
        end
        default: begin
          state_reg        <= IDLE;
          busy_reg         <= 1'b0;
          out_valid_reg    <= 1'b0;
          window_count_reg <= '0;
        end
      endcase
    end
  end

  assign busy         = busy_reg;
  assign out_valid    = out_valid_reg;
  assign window_count = window_count_reg;
  assign out_times    = times_reg;
  assign out_settled  = settled_reg;

endmodule

// File: tb/tb_gamma_window_sequencer.sv
// Directed bench for gamma_window_sequencer (NUM_LINES=4, MAX_VALUE=8, W=4).
module tb_gamma_window_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        clear = 1'b0;
  logic [3:0]  lines = 4'b0000;
  logic        out_ready = 1'b0;
  logic        busy;
  logic [3:0]  window_count;
  logic        out_valid;
  logic [15:0] out_times;
  logic [3:0]  out_settled;

  int vectors = 0;
  int miscompares = 0;

  gamma_window_sequencer #(.NUM_LINES(4), .MAX_VALUE(8)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .clear(clear),
    .lines(lines),
    .out_ready(out_ready),
    .busy(busy),
    .window_count(window_count),
    .out_valid(out_valid),
    .out_times(out_times),
    .out_settled(out_settled)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_idle(input string tag, input logic [15:0] exp_times, input logic [3:0] exp_settled);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " out_valid"}, 32'(out_valid), 32'd0);
    check({tag, " window_count"}, 32'(window_count), 32'd0);
    check({tag, " out_times"}, 32'(out_times), 32'(exp_times));
    check({tag, " out_settled"}, 32'(out_settled), 32'(exp_settled));
  endtask

  task automatic check_loaded(input string tag);
    check({tag, " busy"}, 32'(busy), 32'd1);
    check({tag, " out_valid"}, 32'(out_valid), 32'd0);
    check({tag, " window_count"}, 32'(window_count), 32'd8);
    check({tag, " out_times"}, 32'(out_times), 32'h8888);
    check({tag, " out_settled"}, 32'(out_settled), 32'd0);
  endtask

  task automatic check_done(input string tag, input logic [15:0] exp_times, input logic [3:0] exp_settled);
    check({tag, " busy"}, 32'(busy), 32'd1);
    check({tag, " out_valid"}, 32'(out_valid), 32'd1);
    check({tag, " window_count"}, 32'(window_count), 32'd0);
    check({tag, " out_times"}, 32'(out_times), 32'(exp_times));
    check({tag, " out_settled"}, 32'(out_settled), 32'(exp_settled));
  endtask

  initial begin
    logic [7:0] pat3;
    pat3 = 8'b0000_1101;  // line3 H,L,H,H,L,L,L,L on RUN edges 0..7

    // Reset state, checked before any clock edge.
    #1 reset = 1'b1;
    #1 check_idle("reset", 16'h8888, 4'b0000);
    tick();
    reset = 1'b0;
    tick();

    // clear beats start in IDLE.
    start = 1'b1; clear = 1'b1;
    tick();
    check("clear_prio busy", 32'(busy), 32'd0);
    start = 1'b0; clear = 1'b0;

    // Encoding window.
    start = 1'b1;
    tick();
    check_loaded("enc_load");
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      lines = {pat3[k], 1'b1, (k < 3) ? 1'b1 : 1'b0, 1'b0};
      tick();
      if (k < 7) check($sformatf("enc edge%0d out_valid", k), 32'(out_valid), 32'd0);
    end
    check_done("enc_done", 16'h5058, 4'b1011);

    // Backpressure: start pulses and line activity must not disturb DONE.
    for (int c = 0; c < 5; c++) begin
      start = c[0];
      lines = 4'(c * 5 + 3);
      tick();
      check_done($sformatf("bp%0d", c), 16'h5058, 4'b1011);
    end

    // Back-to-back: accept and restart on the same edge.
    out_ready = 1'b1; start = 1'b1;
    tick();
    check_loaded("b2b_load");
    out_ready = 1'b0; start = 1'b0;
    lines = 4'b0101;
    repeat (8) tick();
    check_done("b2b_done", 16'h8080, 4'b1010);
    out_ready = 1'b1;
    tick();
    check_idle("b2b_accept", 16'h8080, 4'b1010);
    out_ready = 1'b0;

    // Abort on the 4th RUN edge; fields keep their 3-edge values.
    lines = 4'b1111;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_idle("abort", 16'h5555, 4'b0000);
    for (int c = 0; c < 12; c++) begin
      tick();
      check($sformatf("abort after%0d out_valid", c), 32'(out_valid), 32'd0);
    end

    // Async reset during the 5th RUN cycle, between clock edges.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("areset pre window_count", 32'(window_count), 32'd4);
    #2 reset = 1'b1;
    #1 check_idle("areset", 16'h8888, 4'b0000);
    tick();
    reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      check($sformatf("areset after%0d out_valid", c), 32'(out_valid), 32'd0);
    end

    // First start after reset loads normally.
    start = 1'b1;
    tick();
    start = 1'b0;
    check_loaded("post_reset_load");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
